// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: event/button inputs and state/score outputs between the game controller and the pong datapath
interface pong_game_ctrl_if;
  logic       refr_tick;
  logic [1:0] button;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic       ball_reload;
  logic [7:0] score;
  logic [1:0] lives;
  logic [1:0] game_state;
  modport master (output refr_tick, button, hit, miss, input gra_still, ball_reload, score, lives, game_state);
  modport slave (input refr_tick, button, hit, miss, output gra_still, ball_reload, score, lives, game_state);
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer owning state, BCD score, lives and inter-ball delay; PONG_CTRL_AUTOSERVE_EN serves new balls without a button press
module pong_game_ctrl #(
  parameter int LIVES      = 3,
  parameter int WAIT_TICKS = 120
) (
  input logic             clk,
  input logic             reset,
  pong_game_ctrl_if.slave bus
);
  typedef enum logic [1:0] {NEWGAME = 2'b00, PLAY = 2'b01, NEWBALL = 2'b10, OVER = 2'b11} state_t;
  state_t     state, state_n;
  logic [7:0] timer, score_r;
  logic [1:0] lives_r;
  logic       reload_r, press, serve;
  assign press = |bus.button;
`ifdef PONG_CTRL_AUTOSERVE_EN
  assign serve = 1'b1;
`else
  assign serve = press;
`endif
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic carry;
    carry = s[3:0] == 4'd9;
    return {carry ? (s[7:4] == 4'd9 ? 4'd0 : s[7:4] + 4'd1) : s[7:4], carry ? 4'd0 : s[3:0] + 4'd1};
  endfunction
  always_ff @(posedge clk)
    if (reset) state <= NEWGAME;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      NEWGAME: state_n = press ? PLAY : NEWGAME;
      PLAY:    state_n = !bus.miss ? PLAY : (lives_r <= 2'd1 ? OVER : NEWBALL);
      NEWBALL: state_n = (timer == 8'd0 && serve) ? PLAY : NEWBALL;
      OVER:    state_n = timer == 8'd0 ? NEWGAME : OVER;
    endcase
  end
  // miss outranks hit in PLAY; countdowns only advance on frame ticks in the waiting states
  always_ff @(posedge clk)
    if (reset) begin
      score_r  <= 8'h00;
      lives_r  <= 2'(LIVES);
      timer    <= 8'd0;
      reload_r <= 1'b0;
    end else begin
      reload_r <= state != PLAY && state_n == PLAY;
      case (state)
        NEWGAME: begin
          score_r <= 8'h00;
          lives_r <= 2'(LIVES);
        end
        PLAY:
          if (bus.miss) begin
            lives_r <= lives_r - 2'd1;
            timer   <= 8'(WAIT_TICKS);
          end else if (bus.hit) score_r <= bcd_inc(score_r);
        NEWBALL:
          if (bus.refr_tick && timer != 8'd0) timer <= timer - 8'd1;
        OVER:
          if (timer == 8'd0) begin
            score_r <= 8'h00;
            lives_r <= 2'(LIVES);
          end else if (bus.refr_tick) timer <= timer - 8'd1;
      endcase
    end
  always_comb begin
    bus.gra_still   = state != PLAY;
    bus.game_state  = state;
    bus.ball_reload = reload_r;
    bus.score       = score_r;
    bus.lives       = lives_r;
  end
endmodule
